// File: rtl/exram_bus_cycle_gen_pkg.sv
// Shared types and default timing for the external-RAM bus cycle generator.
package exram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  localparam int EXRAM_SETUP_DEF  = 1;
  localparam int EXRAM_STROBE_DEF = 2;
  localparam int EXRAM_HOLD_DEF   = 1;

  localparam int CNT_W = $clog2(16) + 1;

  // Value loaded into the phase down-counter on phase entry.
  function automatic logic [CNT_W-1:0] phase_load(input int cyc);
    logic [31:0] v;
    v = cyc - 1;
    return v[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/exram_bus_cycle_gen_if.sv
// Board-level asynchronous SRAM pin bundle; master is the cycle generator.
interface exram_bus_cycle_gen_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_dq_o;
  logic              ext_dq_oe;
  logic [DATA_W-1:0] ext_dq_i;
  logic              ext_ce_n;
  logic              ext_we_n;
  logic              ext_oe_n;

  modport master (
    output ext_addr, ext_dq_o, ext_dq_oe, ext_ce_n, ext_we_n, ext_oe_n,
    input  ext_dq_i
  );

  modport slave (
    input  ext_addr, ext_dq_o, ext_dq_oe, ext_ce_n, ext_we_n, ext_oe_n,
    output ext_dq_i
  );
endinterface

// File: rtl/exram_bus_cycle_gen.sv
// Turns held active-low read/write requests into one timed SRAM bus cycle each,
// with programmable setup/strobe/hold phases and registered pin outputs.
module exram_bus_cycle_gen
  import exram_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int SETUP_CYC  = EXRAM_SETUP_DEF,
  parameter int STROBE_CYC = EXRAM_STROBE_DEF,
  parameter int HOLD_CYC   = EXRAM_HOLD_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_n,
  input  logic                  rd_n,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata,
  output logic                  busy,
  exram_bus_cycle_gen_if.master sram
);

  localparam logic [CNT_W-1:0] SETUP_LD  = phase_load(SETUP_CYC);
  localparam logic [CNT_W-1:0] STROBE_LD = phase_load(STROBE_CYC);
  localparam logic [CNT_W-1:0] HOLD_LD   = phase_load(HOLD_CYC);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  state_e            state_r, state_s;
  op_e               op_r, op_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              latch_s, capture_s, active_s;
  logic              busy_s, ce_n_s, we_n_s, oe_n_s, dq_oe_s;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r, rdata_r;
  logic              busy_r, ce_n_r, we_n_r, oe_n_r, dq_oe_r;

  // Next-state, phase counter and next pin values; pins are decoded from the
  // next state so that they become valid in the same cycle as the state.
  always_comb begin
    state_s   = state_r;
    op_s      = op_r;
    cnt_s     = cnt_r;
    latch_s   = 1'b0;
    capture_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!wr_n || !rd_n) begin
          latch_s = 1'b1;
          op_s    = (!wr_n) ? OP_WR : OP_RD;
          if (SETUP_CYC > 0) begin
            state_s = ST_SETUP;
            cnt_s   = SETUP_LD;
          end else begin
            state_s = ST_STROBE;
            cnt_s   = STROBE_LD;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_STROBE;
          cnt_s   = STROBE_LD;
        end else begin
          cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_STROBE: begin
        if (cnt_r == CNT_ZERO) begin
          capture_s = (op_r == OP_RD);
          if (HOLD_CYC > 0) begin
            state_s = ST_HOLD;
            cnt_s   = HOLD_LD;
          end else begin
            state_s = ST_RELEASE;
          end
        end else begin
          cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_HOLD: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_RELEASE;
        end else begin
          cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_RELEASE: begin
        if (wr_n && rd_n) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RELEASE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase

    active_s = (state_s == ST_SETUP) || (state_s == ST_STROBE) || (state_s == ST_HOLD);
    busy_s   = (state_s != ST_IDLE);
    ce_n_s   = !active_s;
    we_n_s   = !((state_s == ST_STROBE) && (op_s == OP_WR));
    oe_n_s   = !((state_s == ST_STROBE) && (op_s == OP_RD));
    dq_oe_s  = active_s && (op_s == OP_WR);
  end

  // State, latched request and registered pin outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      op_r    <= OP_RD;
      cnt_r   <= CNT_ZERO;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      rdata_r <= {DATA_W{1'b0}};
      busy_r  <= 1'b0;
      ce_n_r  <= 1'b1;
      we_n_r  <= 1'b1;
      oe_n_r  <= 1'b1;
      dq_oe_r <= 1'b0;
    end else begin
      state_r <= state_s;
      op_r    <= op_s;
      cnt_r   <= cnt_s;
      if (latch_s) begin
        addr_r  <= addr;
        wdata_r <= wdata;
      end
      if (capture_s) begin
        rdata_r <= sram.ext_dq_i;
      end
      busy_r  <= busy_s;
      ce_n_r  <= ce_n_s;
      we_n_r  <= we_n_s;
      oe_n_r  <= oe_n_s;
      dq_oe_r <= dq_oe_s;
    end
  end

  assign rdata          = rdata_r;
  assign busy           = busy_r;
  assign sram.ext_addr  = addr_r;
  assign sram.ext_dq_o  = wdata_r;
  assign sram.ext_dq_oe = dq_oe_r;
  assign sram.ext_ce_n  = ce_n_r;
  assign sram.ext_we_n  = we_n_r;
  assign sram.ext_oe_n  = oe_n_r;

endmodule

// File: tb/tb_exram_bus_cycle_gen.sv
// Scoreboard bench: one DUT with default timing, one with setup=0/strobe=1/hold=0;
// per-cycle expected pin vectors come from the timing formulas of each bus cycle.
module tb_exram_bus_cycle_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_n_v [2];
  logic        rd_n_v [2];
  logic [15:0] addr_v [2];
  logic [7:0]  wdata_v[2];
  logic [7:0]  rdata_v[2];
  logic        busy_v [2];

  exram_bus_cycle_gen_if #(.ADDR_W(16), .DATA_W(8)) if_a();
  exram_bus_cycle_gen_if #(.ADDR_W(16), .DATA_W(8)) if_b();

  exram_bus_cycle_gen #(.ADDR_W(16), .DATA_W(8), .SETUP_CYC(1), .STROBE_CYC(2), .HOLD_CYC(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_n(wr_n_v[0]), .rd_n(rd_n_v[0]), .addr(addr_v[0]),
    .wdata(wdata_v[0]), .rdata(rdata_v[0]), .busy(busy_v[0]), .sram(if_a.master));

  exram_bus_cycle_gen #(.ADDR_W(16), .DATA_W(8), .SETUP_CYC(0), .STROBE_CYC(1), .HOLD_CYC(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_n(wr_n_v[1]), .rd_n(rd_n_v[1]), .addr(addr_v[1]),
    .wdata(wdata_v[1]), .rdata(rdata_v[1]), .busy(busy_v[1]), .sram(if_b.master));

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] exp_q[$];
  logic [15:0] m_addr [2];
  logic [7:0]  m_dq_o [2];
  logic [7:0]  m_rdata[2];
  int          t_setup [2] = '{1, 0};
  int          t_strobe[2] = '{2, 1};
  int          t_hold  [2] = '{1, 0};

  function automatic logic [63:0] pack(input logic busy, input logic ce_n, input logic we_n,
                                       input logic oe_n, input logic dq_oe, input logic [15:0] a,
                                       input logic [7:0] dq, input logic [7:0] rd);
    return {27'd0, busy, ce_n, we_n, oe_n, dq_oe, a, dq, rd};
  endfunction

  function automatic logic [63:0] observe(input int sel);
    if (sel == 0)
      return pack(busy_v[0], if_a.ext_ce_n, if_a.ext_we_n, if_a.ext_oe_n, if_a.ext_dq_oe,
                  if_a.ext_addr, if_a.ext_dq_o, rdata_v[0]);
    else
      return pack(busy_v[1], if_b.ext_ce_n, if_b.ext_we_n, if_b.ext_oe_n, if_b.ext_dq_oe,
                  if_b.ext_addr, if_b.ext_dq_o, rdata_v[1]);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got busy/ce/we/oe/oe_dq/addr/dq/rdata=%b%b%b%b%b/%h/%h/%h expected %b%b%b%b%b/%h/%h/%h",
               tag, obs[36], obs[35], obs[34], obs[33], obs[32], obs[31:16], obs[15:8], obs[7:0],
               exp[36], exp[35], exp[34], exp[33], exp[32], exp[31:16], exp[15:8], exp[7:0]);
    end
  endtask

  task automatic set_dqi(input int sel, input logic [7:0] v);
    if (sel == 0) if_a.ext_dq_i = v;
    else          if_b.ext_dq_i = v;
  endtask

  // One request held for hold_len cycles; rst_cyc>0 pulls reset during that cycle.
  task automatic run_txn(input int sel, input string name, input logic do_wr, input logic do_rd,
                         input logic [15:0] a, input logic [7:0] d, input logic [7:0] dqi,
                         input int hold_len, input int rst_cyc);
    int s, st, h, r, last, n;
    logic is_wr, is_rd, act, stb;
    logic [7:0] old_rd;
    s = t_setup[sel]; st = t_strobe[sel]; h = t_hold[sel];
    r = s + st + h + 1;
    last = (hold_len > r) ? hold_len : r;
    n = (rst_cyc > 0) ? rst_cyc + 1 : last + 2;
    is_wr = do_wr;
    is_rd = !do_wr;
    old_rd = m_rdata[sel];
    for (int k = 1; k <= n; k++) begin
      if (rst_cyc > 0 && k == rst_cyc + 1) begin
        exp_q.push_back(pack(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 8'h00));
      end else begin
        act = (k <= s + st + h);
        stb = (k >= 1 + s) && (k <= s + st);
        exp_q.push_back(pack(k <= last, !act, !(stb && is_wr), !(stb && is_rd), act && is_wr,
                             a, d, (is_rd && k >= 1 + s + st) ? dqi : old_rd));
      end
    end
    if (rst_cyc > 0) begin
      for (int j = 0; j < 2; j++) begin
        m_addr[j] = 16'h0000; m_dq_o[j] = 8'h00; m_rdata[j] = 8'h00;
      end
    end else begin
      m_addr[sel] = a; m_dq_o[sel] = d;
      m_rdata[sel] = is_rd ? dqi : old_rd;
    end

    @(negedge clk);
    addr_v[sel] = a; wdata_v[sel] = d;
    wr_n_v[sel] = !do_wr; rd_n_v[sel] = !do_rd;
    set_dqi(sel, ~dqi);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      wr_n_v[sel] = !(do_wr && k < hold_len);
      rd_n_v[sel] = !(do_rd && k < hold_len);
      addr_v[sel] = ~a; wdata_v[sel] = ~d;
      set_dqi(sel, ((k >= 1 + s) && (k <= s + st)) ? dqi : ~dqi);
      if (rst_cyc > 0 && k == rst_cyc) begin
        rst_n = 1'b0; wr_n_v[sel] = 1'b1; rd_n_v[sel] = 1'b1;
      end
      if (rst_cyc > 0 && k == rst_cyc + 1) rst_n = 1'b1;
      @(negedge clk);
      check_eq($sformatf("%s c%0d", name, k), observe(sel), exp_q.pop_front());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int j = 0; j < 2; j++) begin
      wr_n_v[j] = 1'b1; rd_n_v[j] = 1'b1; addr_v[j] = 16'h0000; wdata_v[j] = 8'h00;
      m_addr[j] = 16'h0000; m_dq_o[j] = 8'h00; m_rdata[j] = 8'h00;
    end
    if_a.ext_dq_i = 8'h00;
    if_b.ext_dq_i = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      exp_q.push_back(pack(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 8'h00));
      check_eq($sformatf("reset dut%0d", j), observe(j), exp_q.pop_front());
    end
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(0, "wr_def",   1'b1, 1'b0, 16'h1234, 8'hA5, 8'h00, 1, 0);
    run_txn(0, "rd_def",   1'b0, 1'b1, 16'h00FF, 8'h10, 8'h3C, 1, 0);
    run_txn(0, "rd_held",  1'b0, 1'b1, 16'h0ABC, 8'h20, 8'h5A, 20, 0);
    run_txn(1, "wr_fast",  1'b1, 1'b0, 16'hBEEF, 8'h77, 8'h00, 1, 0);
    run_txn(1, "rd_fast",  1'b0, 1'b1, 16'h0100, 8'h30, 8'h99, 1, 0);
    run_txn(1, "wr_fheld", 1'b1, 1'b0, 16'h7F00, 8'h42, 8'h00, 4, 0);
    run_txn(0, "both_low", 1'b1, 1'b1, 16'h2222, 8'h11, 8'hEE, 1, 0);
    run_txn(0, "rd_rst",   1'b0, 1'b1, 16'h4444, 8'h40, 8'h66, 1, 2);
    run_txn(0, "wr_post",  1'b1, 1'b0, 16'h5555, 8'hC3, 8'h00, 1, 0);
    run_txn(0, "rd_post",  1'b0, 1'b1, 16'h5555, 8'h50, 8'h81, 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
